cla_slice_sequencer: RTL
========================

Name: cla_slice_sequencer

Overview:
- Multi-cycle wide adder front/back end for the existing 5-bit cla_adder slice.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Feeds the operands to one cla_adder instance 5 bits per cycle, LSB slice first, and registers the carry between slices.
- Assembles the WIDTH-bit sum and final carry-out and presents them on an output valid/ready handshake.

Parameters:
- WIDTH, 20, operand and sum width in bits. Must be a multiple of SLICE and at least SLICE; any other value is an elaboration error.
- SLICE, 5, slice width. Fixed to the cla_adder width; not overridable in practice.
- NSLICE, WIDTH/SLICE, derived localparam giving the number of slice cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept an operand
- op_a  in  WIDTH  addend A
- op_b  in  WIDTH  addend B
- cin  in  1  carry into slice 0
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered sum
- cout  out  1  registered carry out of the top slice
- busy  out  1  high in RUN state

Behaviour:
- Reset is asynchronous and active-low: rst_n low immediately forces all of the following.
  - State = IDLE.
  - in_ready = 1.
  - out_valid = 0, busy = 0.
  - sum = 0, cout = 0.
  - Slice index, carry register and operand shift registers = 0.
- Reset mid-operation discards the operation; no partial result is ever presented.
- States and transitions:
  - IDLE: in_ready = 1. in_valid & in_ready at an edge captures op_a, op_b and cin into internal registers, sets idx = 0, goes to RUN.
  - RUN: in_ready = 0, busy = 1. Each cycle, slice idx of A and B plus the carry register drive the cla_adder.
    - At the edge, the slice result is written into sum[idx*5 +: 5].
    - The carry register takes the slice cout.
    - idx increments.
    - When idx == NSLICE-1 at that edge: cout takes the slice cout and the state goes to DONE.
  - DONE: out_valid = 1; sum and cout are stable and must not change while out_valid = 1 and out_ready = 0. out_ready = 1 at an edge returns the state to IDLE and drops out_valid.
- Latency: out_valid rises exactly NSLICE clock edges after the accept edge (4 for WIDTH = 20). Minimum period between accepts is NSLICE + 2 cycles.
- in_valid while not IDLE is ignored. Operands need not be held after the accept edge.
- out_ready while not DONE has no effect.
- sum keeps the last result after DONE → IDLE until the next RUN begins overwriting it.
- Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only via cout. {cout, sum} == op_a + op_b + cin, all zero-extended.
- Implementation choice: an indexed slice or right-shifting operand registers; both are acceptable provided the cycle behaviour above holds.

Decomposition:
- Shared package cla_pkg holds:
  - SLICE_W = 5;
  - a state enum {IDLE, RUN, DONE};
  - function nslice(width), which returns width / SLICE_W.
- One sub-module: the existing cla_adder, instantiated once as the slice datapath. All sequencing stays in cla_slice_sequencer.

Test Plan:
- Ripple across all slices: WIDTH = 20, op_a = 0xFFFFF, op_b = 0x00001, cin = 0 → out_valid exactly 4 edges after accept; sum = 0x00000, cout = 1.
- Carry-in only: op_a = 0x00000, op_b = 0x00000, cin = 1 → sum = 0x00001, cout = 0.
- Mixed operands: op_a = 0x12345, op_b = 0x0ABCD, cin = 0 → sum = 0x1CF12, cout = 0.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → out_valid stays 1, sum/cout unchanged, in_ready = 0, and in_valid pulses during that time are ignored. Then out_ready = 1 → IDLE next edge, in_ready = 1.
- Reset mid-RUN: assert rst_n = 0 two cycles after accepting 0xFFFFF + 0xFFFFF → out_valid, sum and cout all 0 at once; no result appears after release. A new op 0x00003 + 0x00004 then gives sum = 0x00007.
- Randomised back-to-back ops (1000) with in_valid held high → every result matches the reference model {cout, sum} = a + b + cin, and no operation is dropped or duplicated.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the CLA slice sequencer.
//   SLICE_W : width of the cla_adder slice datapath
//   state_t : sequencer state encoding (IDLE, RUN, DONE)
//   nslice  : number of slice cycles needed for a given operand width
package cla_pkg;

  localparam int unsigned SLICE_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned nslice(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// 5-bit carry-lookahead adder slice (purely combinational).
// Ports:
//   a, b  : 5-bit addends
//   cin   : carry in
//   sum   : 5-bit sum
//   cout  : carry out of bit 4
module cla_adder (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);

  logic [4:0] g;
  logic [4:0] p;
  logic [5:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded from generate/propagate terms and cin,
  // so no carry depends on the one below it.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
              | (p[4] & p[3] & p[2] & g[1])
              | (p[4] & p[3] & p[2] & p[1] & g[0])
              | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[4:0];
  assign cout = c[5];

endmodule

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder built around a single 5-bit cla_adder.
// Operands are captured on an input handshake, added one slice per cycle
// (LSB slice first) with the carry registered between slices, and the
// result is held on an output handshake.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (op_a, op_b, cin)
//   out_valid / out_ready: result handshake (sum, cout)
//   busy                 : high while slices are being added
module cla_slice_sequencer
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NSLICE = nslice(WIDTH);
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((SLICE != SLICE_W) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_width
    $error("cla_slice_sequencer: WIDTH must be a non-zero multiple of the 5-bit slice");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic             cout_q;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic             last;

  assign last = (idx == IDXW'(NSLICE - 1));

  // Operands shift right each RUN cycle, so the adder always sees bits [4:0].
  cla_adder u_slice (
    .a    (a_sh[SLICE-1:0]),
    .b    (b_sh[SLICE-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_sh  <= op_a;
        b_sh  <= op_b;
        carry <= cin;
        idx   <= '0;
      end
    end else if (state == RUN) begin
      a_sh  <= a_sh >> SLICE;
      b_sh  <= b_sh >> SLICE;
      carry <= slice_cout;
      idx   <= idx + 1'b1;
      for (int unsigned i = 0; i < NSLICE; i++) begin
        if (idx == IDXW'(i)) sum_q[i*SLICE +: SLICE] <= slice_sum;
      end
      if (last) cout_q <= slice_cout;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
